// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM states, init ROM and HD44780 command constants for the LCD bus scheduler
package lcd_pkg;
  typedef enum logic [2:0] {S_POWERUP, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_IDLE} lcd_state_t;
  localparam int INIT_LEN = 8;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] HOME       = 8'h02;
  localparam logic [7:0] FUNC_8B_2L = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_INC  = 8'h06;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h30, 8'h30, 8'h30, FUNC_8B_2L, 8'h08, CLEAR, ENTRY_INC, DISP_ON};
  // clear (0x01) and home (0x02/0x03) are the only instructions needing the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && d[7:2] == 6'd0;
  endfunction
endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter that holds at zero and flags it
//   clk      system clock
//   i_load   load i_value this cycle (also used as the reset path by the parent)
//   i_value  count to load; a value of N-1 gives a state lasting N cycles
//   o_done   count has reached zero
module lcd_delay_timer #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;
  assign o_done = r_cnt == '0;
  always_ff @(posedge clk)
    r_cnt <= i_load ? i_value : o_done ? r_cnt : r_cnt - CNT_W'(1);
endmodule

// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: HD44780 8-bit bus owner running power-up init, then round-robin cmd/chr writes
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_data/cmd_ready   instruction requester (RS=0)
//   chr_valid/chr_data/chr_ready   character requester (RS=1)
//   init_done, busy                status
//   RS, RW, E, data                LCD pins
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int T_POWERUP   = 2_000_000,
  parameter int T_SETUP     = 4,
  parameter int T_PULSE     = 25,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2_500,
  parameter int T_EXEC_LONG = 82_000,
  parameter int CNT_W       = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       chr_valid,
  input  logic [7:0] chr_data,
  output logic       chr_ready,
  output logic       init_done,
  output logic       busy,
  output logic       RS,
  output logic       RW,
  output logic       E,
  output logic [7:0] data
);
  lcd_state_t       r_state, w_next;
  logic [2:0]       r_idx;
  logic             r_ptr, r_rs, r_init_done;
  logic [7:0]       r_data;
  logic             w_done, w_load, w_long, w_last, w_grant;
  logic [CNT_W-1:0] w_value;
  // r_ptr: 0 favours the command port, 1 the character port
  assign w_grant   = r_state == S_IDLE && r_init_done;
  assign cmd_ready = w_grant && cmd_valid && (!chr_valid || !r_ptr);
  assign chr_ready = w_grant && chr_valid && (!cmd_valid || r_ptr);
  assign w_last    = r_idx == 3'(INIT_LEN - 1);
  assign w_long    = is_long_cmd(r_rs, r_data) || (!r_init_done && r_idx == 3'd0);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_POWERUP: w_next = w_done ? S_SETUP : S_POWERUP;
      S_SETUP:   w_next = w_done ? S_PULSE : S_SETUP;
      S_PULSE:   w_next = w_done ? S_HOLD : S_PULSE;
      S_HOLD:    w_next = w_done ? S_EXEC : S_HOLD;
      S_EXEC:    w_next = !w_done ? S_EXEC : (r_init_done || w_last) ? S_IDLE : S_SETUP;
      S_IDLE:    w_next = (cmd_ready || chr_ready) ? S_SETUP : S_IDLE;
      default:   w_next = S_POWERUP;
    endcase
  end
  // every state change reloads the timer with the new state's length minus one
  assign w_load  = rst || w_next != r_state;
  assign w_value = rst               ? CNT_W'(T_POWERUP - 1) :
                   w_next == S_SETUP ? CNT_W'(T_SETUP - 1) :
                   w_next == S_PULSE ? CNT_W'(T_PULSE - 1) :
                   w_next == S_HOLD  ? CNT_W'(T_HOLD - 1) :
                   w_next == S_EXEC  ? (w_long ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1)) : '0;
  lcd_delay_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .i_load  (w_load),
    .i_value (w_value),
    .o_done  (w_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_POWERUP;
      r_idx       <= '0;
      r_ptr       <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_POWERUP && w_done) begin
        r_rs   <= 1'b0;
        r_data <= INIT_ROM[0];
      end
      if (r_state == S_EXEC && w_done && !r_init_done) begin
        if (w_last) r_init_done <= 1'b1;
        else begin
          r_idx  <= r_idx + 3'd1;
          r_rs   <= 1'b0;
          r_data <= INIT_ROM[r_idx + 3'd1];
        end
      end
      if (cmd_ready) begin
        r_rs   <= 1'b0;
        r_data <= cmd_data;
        r_ptr  <= 1'b1;
      end
      if (chr_ready) begin
        r_rs   <= 1'b1;
        r_data <= chr_data;
        r_ptr  <= 1'b0;
      end
    end
  end
  assign E         = r_state == S_PULSE;
  assign RS        = r_rs;
  assign RW        = 1'b0;
  assign data      = r_data;
  assign busy      = r_state != S_IDLE;
  assign init_done = r_init_done;
endmodule
